td4_prog_loader: RTL and testbench
==================================

# td4_prog_loader

Writable program store plus switch-driven load controller for the TD4 CPU. It is the writer side of the CPU's instruction fetch path. It replaces the fixed ROM with a 16×8 memory that the CPU reads combinationally. While the operator is in program mode, it holds the CPU in reset and lets the operator enter bytes one at a time from slide switches and a write button.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the synchronized write button changes debounced level (range 1–65535; boards use ~500000/clock-divider, sim uses 4).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  synchronous, active-low reset.
- mode_sw  input  1  raw switch; 1 = request program mode, 0 = run.
- wr_key  input  1  raw write button, active-high, bouncy.
- data_sw  input  8  byte to store on each accepted press.
- cpu_addr  input  4  CPU fetch address (program counter).
- cpu_qd  output  8  instruction byte mem[cpu_addr], combinational read.
- cpu_rst_n  output  1  registered; drives the CPU's active-low reset.
- loading  output  1  registered; 1 while in LOAD or RELEASE.
- wr_addr  output  4  registered; next write pointer.
- full  output  1  registered; sticky once 16 bytes have been written in the current LOAD session.

## Operation
- Input conditioning: mode_sw and wr_key each pass through a 2-flop synchronizer (m_s2, k_s2).
- Debounce: the debounced level kdb starts at 0.
  - The counter increments while k_s2 != kdb and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, kdb takes k_s2 and the counter clears.
  - A 0→1 flip of kdb is an accepted press.
- FSM states: RUN, LOAD, RELEASE.
  - RUN: cpu_rst_n=1, loading=0. If m_s2=1, go to LOAD, set wr_addr←0 and full←0.
  - LOAD: cpu_rst_n=0, loading=1.
    - On an accepted press: mem[wr_addr]←data_sw, wr_addr←wr_addr+1 (mod 16).
    - On a write at wr_addr=15, set full←1 and wrap wr_addr to 0.
    - Further presses overwrite from address 0; full stays 1.
    - If m_s2=0, go to RELEASE.
  - RELEASE: exactly one cycle, cpu_rst_n=0, loading=1, then go to RUN. This guarantees the CPU gets at least one clean reset cycle after the last write.
- Simultaneous events: if an accepted press and m_s2=0 occur in the same LOAD cycle, the exit wins and no write happens. Presses in RUN and RELEASE are ignored but still update kdb.
- data_sw is sampled unsynchronized at the write edge. The operator must hold it stable, so no synchronizer is applied.
- Read port: cpu_qd = mem[cpu_addr] at all times, including during LOAD. The CPU is in reset then, so the value is don't-care.

## Timing
- Reset (RST=0 at a rising edge) produces:
  - state=RUN, cpu_rst_n=1, loading=0, wr_addr=0, full=0, kdb=0, counter=0;
  - synchronizers cleared;
  - all 16 mem entries cleared to 8'h00, so cpu_qd=8'h00 for any address.
- Reset mid-LOAD aborts the session and clears the memory. Bytes already written are lost.
- Mode latency: raw mode_sw=1 before edge k gives m_s2=1 after edge k+1, and LOAD plus cpu_rst_n=0 after edge k+2.
  - Exit: raw 0 before edge k gives RELEASE after edge k+2 and RUN with cpu_rst_n=1 after edge k+3.
- Write latency: raw wr_key held 1 from before edge k gives k_s2=1 after edge k+1. The write commits at edge k+1+DEBOUNCE_CYCLES.
  - cpu_qd reflects the new byte immediately after that edge when cpu_addr matches.
  - Any bounce (k_s2 returning to kdb) before the count completes restarts the count.
- A second press requires kdb to return to 0, which takes DEBOUNCE_CYCLES stable-low cycles.

## Structure
- Shared package td4_pkg: ADDR_W=4, DATA_W=8, MEM_DEPTH=16, and an enum for the loader states RUN/LOAD/RELEASE.
- One sub-module, debounce: synchronizer, counter and kdb, with output press_pulse.
- The FSM and memory array live in td4_prog_loader.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- Reset: hold RST=0 for 2 cycles, release → cpu_rst_n=1, loading=0, wr_addr=0, full=0, cpu_qd=8'h00 for cpu_addr=0..15.
- Basic load: mode_sw=1; press wr_key for 10 cycles with data_sw=8'hB3, then 8'h01, 8'h90; mode_sw=0 →
  - mem[0..2]=B3,01,90 and wr_addr=3;
  - cpu_rst_n is 0 from edge k+2 of mode entry until one RELEASE cycle after exit;
  - then cpu_qd at cpu_addr=1 is 8'h01.
- Bounce rejection: in LOAD, toggle wr_key 1,0,1,0 each cycle, then hold 1 →
  - exactly one write, committed 5 edges after the steady-1 sample;
  - wr_addr advances by 1.
- Wrap and full: make 17 accepted presses with data_sw = press index (0x00..0x10) →
  - full=1 after the 16th press;
  - wr_addr=1;
  - mem[0]=8'h10, mem[15]=8'h0F.
- Simultaneous exit: align the debounced press edge with m_s2 falling → no write, wr_addr unchanged, RELEASE then RUN.
- Reset mid-load: after 3 writes, assert RST=0 for 1 cycle → state RUN, cpu_rst_n=1, wr_addr=0, all mem 8'h00.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program store and loader.
package td4_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 16;

    // Loader controller states.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } loader_state_t;

    // Next write pointer; wraps naturally at MEM_DEPTH.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    // True when a write at this address fills the last slot.
    function automatic logic addr_is_last(input logic [ADDR_W-1:0] a);
        return (a == {ADDR_W{1'b1}});
    endfunction

endpackage

// File: rtl/td4_prog_loader_debounce.sv
// Write-button conditioning: 2-flop synchronizer, stability counter and
// debounced level. press_pulse is high during the cycle whose rising edge
// flips the debounced level 0->1, so the consumer commits on that edge.
module debounce
    import td4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_raw,
    output logic press_pulse
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        k_s1_r;
    logic        k_s2_r;
    logic        kdb_r;
    logic [15:0] cnt_r;
    logic        differ_s;
    logic        done_s;

    // Mismatch and terminal-count decode shared by the counter and the pulse.
    always_comb begin
        differ_s    = 1'b0;
        done_s      = 1'b0;
        press_pulse = 1'b0;
        if (k_s2_r != kdb_r) begin
            differ_s    = 1'b1;
            done_s      = (cnt_r == CNT_LAST);
            press_pulse = (cnt_r == CNT_LAST) && k_s2_r;
        end else begin
            differ_s    = 1'b0;
            done_s      = 1'b0;
            press_pulse = 1'b0;
        end
    end

    // Bring the raw button into the clock domain.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            k_s1_r <= 1'b0;
            k_s2_r <= 1'b0;
        end else begin
            k_s1_r <= key_raw;
            k_s2_r <= k_s1_r;
        end
    end

    // Count consecutive cycles of disagreement; adopt the new level once stable.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            kdb_r <= 1'b0;
            cnt_r <= 16'd0;
        end else if (!differ_s) begin
            cnt_r <= 16'd0;
        end else if (done_s) begin
            kdb_r <= k_s2_r;
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/td4_prog_loader.sv
// Writable 16x8 program store for the TD4 CPU plus the switch-driven loader
// that holds the CPU in reset while the operator keys in bytes.
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mode_sw,
    input  logic              wr_key,
    input  logic [DATA_W-1:0] data_sw,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_qd,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              full
);

    loader_state_t     state_r;
    logic              m_s1_r;
    logic              m_s2_r;
    logic              press_s;
    logic              we_s;
    logic [DATA_W-1:0] mem_r [MEM_DEPTH];

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK         (CLK),
        .RST         (RST),
        .key_raw     (wr_key),
        .press_pulse (press_s)
    );

    // Bring the raw mode switch into the clock domain.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            m_s1_r <= 1'b0;
            m_s2_r <= 1'b0;
        end else begin
            m_s1_r <= mode_sw;
            m_s2_r <= m_s1_r;
        end
    end

    // A press only writes while staying in LOAD; leaving LOAD takes priority.
    always_comb begin
        we_s = 1'b0;
        if ((state_r == ST_LOAD) && m_s2_r) begin
            we_s = press_s;
        end else begin
            we_s = 1'b0;
        end
    end

    // Loader FSM with registered CPU reset, status and write pointer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r   <= ST_RUN;
            cpu_rst_n <= 1'b1;
            loading   <= 1'b0;
            wr_addr   <= {ADDR_W{1'b0}};
            full      <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (m_s2_r) begin
                        state_r   <= ST_LOAD;
                        cpu_rst_n <= 1'b0;
                        loading   <= 1'b1;
                        wr_addr   <= {ADDR_W{1'b0}};
                        full      <= 1'b0;
                    end else begin
                        cpu_rst_n <= 1'b1;
                        loading   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cpu_rst_n <= 1'b0;
                    loading   <= 1'b1;
                    if (!m_s2_r) begin
                        state_r <= ST_RELEASE;
                    end else if (we_s) begin
                        wr_addr <= addr_inc(wr_addr);
                        if (addr_is_last(wr_addr)) begin
                            full <= 1'b1;
                        end else begin
                            full <= full;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RELEASE: begin
                    // One guaranteed reset cycle after the last write.
                    state_r   <= ST_RUN;
                    cpu_rst_n <= 1'b1;
                    loading   <= 1'b0;
                end
                default: begin
                    state_r   <= ST_RUN;
                    cpu_rst_n <= 1'b1;
                    loading   <= 1'b0;
                end
            endcase
        end
    end

    // Program store: cleared on reset, written on accepted presses in LOAD.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            mem_r[wr_addr] <= data_sw;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    // Instruction fetch is an asynchronous read of the store.
    always_comb begin
        cpu_qd = mem_r[cpu_addr];
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed self-checking bench for td4_prog_loader (DEBOUNCE_CYCLES = 4).
module tb_td4_prog_loader;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       mode_sw = 1'b0;
    logic       wr_key = 1'b0;
    logic [7:0] data_sw = 8'h00;
    logic [3:0] cpu_addr = 4'h0;
    logic [7:0] cpu_qd;
    logic       cpu_rst_n;
    logic       loading;
    logic [3:0] wr_addr;
    logic       full;

    int n_checks = 0;
    int n_pass   = 0;

    td4_prog_loader #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mode_sw   (mode_sw),
        .wr_key    (wr_key),
        .data_sw   (data_sw),
        .cpu_addr  (cpu_addr),
        .cpu_qd    (cpu_qd),
        .cpu_rst_n (cpu_rst_n),
        .loading   (loading),
        .wr_addr   (wr_addr),
        .full      (full)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic check_mem(input string tag, input logic [3:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check_val(tag, {24'd0, cpu_qd}, {24'd0, exp});
    endtask

    task automatic enter_load();
        mode_sw = 1'b1;
        tick(2);
        check_val("enter_k1_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        tick(1);
        check_val("enter_k2_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("enter_k2_loading", {31'd0, loading}, 32'd1);
        check_val("enter_wr_addr", {28'd0, wr_addr}, 32'd0);
        check_val("enter_full", {31'd0, full}, 32'd0);
    endtask

    task automatic exit_load();
        mode_sw = 1'b0;
        tick(2);
        check_val("exit_k1_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        tick(1);
        check_val("exit_release_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("exit_release_loading", {31'd0, loading}, 32'd1);
        tick(1);
        check_val("exit_run_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_val("exit_run_loading", {31'd0, loading}, 32'd0);
    endtask

    // Hold the key from before edge k; write must land exactly at edge k+5.
    task automatic press(input logic [7:0] d, input logic [3:0] a_before);
        data_sw = d;
        wr_key  = 1'b1;
        tick(5);
        check_val("press_not_early", {28'd0, wr_addr}, {28'd0, a_before});
        tick(1);
        check_val("press_addr_adv", {28'd0, wr_addr}, {28'd0, a_before + 4'd1});
        check_mem("press_data", a_before, d);
        tick(4);
        wr_key = 1'b0;
        tick(8);
    endtask

    initial begin
        // Reset
        tick(1);
        tick(1);
        RST = 1'b1;
        check_val("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_val("rst_loading", {31'd0, loading}, 32'd0);
        check_val("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check_val("rst_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("rst_mem", 4'(i), 8'h00);

        // Basic load
        enter_load();
        press(8'hB3, 4'd0);
        press(8'h01, 4'd1);
        press(8'h90, 4'd2);
        check_val("basic_wr_addr", {28'd0, wr_addr}, 32'd3);
        exit_load();
        check_mem("basic_mem0", 4'd0, 8'hB3);
        check_mem("basic_mem1", 4'd1, 8'h01);
        check_mem("basic_mem2", 4'd2, 8'h90);
        check_val("basic_wr_addr_run", {28'd0, wr_addr}, 32'd3);

        // Bounce rejection
        enter_load();
        data_sw = 8'h5A;
        wr_key = 1'b1; tick(1);
        wr_key = 1'b0; tick(1);
        wr_key = 1'b1; tick(1);
        wr_key = 1'b0; tick(1);
        check_val("bounce_no_write", {28'd0, wr_addr}, 32'd0);
        press(8'h5A, 4'd0);
        check_val("bounce_single", {28'd0, wr_addr}, 32'd1);
        exit_load();

        // Wrap and full
        enter_load();
        for (int i = 0; i < 17; i++) begin
            press(8'(i), 4'(i));
            if (i == 14) check_val("full_before_16", {31'd0, full}, 32'd0);
            if (i == 15) begin
                check_val("full_at_16", {31'd0, full}, 32'd1);
                check_val("wrap_addr_16", {28'd0, wr_addr}, 32'd0);
            end
        end
        check_val("wrap_full_17", {31'd0, full}, 32'd1);
        check_val("wrap_addr_17", {28'd0, wr_addr}, 32'd1);
        check_mem("wrap_mem0", 4'd0, 8'h10);
        check_mem("wrap_mem15", 4'd15, 8'h0F);
        check_mem("wrap_mem7", 4'd7, 8'h07);

        // Simultaneous exit: press accepted at edge k+5, exit decided at k+5
        data_sw = 8'hEE;
        wr_key = 1'b1;
        tick(3);
        mode_sw = 1'b0;
        tick(3);
        check_val("simul_wr_addr", {28'd0, wr_addr}, 32'd1);
        check_val("simul_release_loading", {31'd0, loading}, 32'd1);
        check_val("simul_release_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_mem("simul_mem1", 4'd1, 8'h01);
        tick(1);
        check_val("simul_run_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_val("simul_run_loading", {31'd0, loading}, 32'd0);
        wr_key = 1'b0;
        tick(8);
        check_mem("simul_mem1_after", 4'd1, 8'h01);

        // Reset mid-load
        enter_load();
        press(8'hAA, 4'd0);
        press(8'hBB, 4'd1);
        press(8'hCC, 4'd2);
        check_val("midrst_wr_addr_pre", {28'd0, wr_addr}, 32'd3);
        mode_sw = 1'b0;
        RST = 1'b0;
        tick(1);
        RST = 1'b1;
        check_val("midrst_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_val("midrst_loading", {31'd0, loading}, 32'd0);
        check_val("midrst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check_val("midrst_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 16; i++) check_mem("midrst_mem", 4'(i), 8'h00);
        tick(4);
        check_val("midrst_stays_run", {31'd0, loading}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
